pixel_write_sink: RTL and testbench

//  Receiving end of the bird/hunter pixel-plot stream (x, y, colour, plot) produced by the draw FSMs.

---
 rtl/duck_hunt_pkg.sv | 27 ++
 rtl/pixel_fifo.sv | 60 ++++++
 rtl/pixel_write_sink.sv | 185 ++++++++++++++++++
 tb/tb_pixel_write_sink.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/duck_hunt_pkg.sv
// Shared constants and types for the duck-hunt framebuffer path.
package duck_hunt_pkg;

    localparam int unsigned H_RES     = 160;
    localparam int unsigned V_RES     = 120;
    localparam int unsigned FB_ADDR_W = 15;
    localparam int unsigned COLOUR_W  = 3;
    localparam int unsigned FIFO_W    = FB_ADDR_W + COLOUR_W;

    localparam logic [COLOUR_W-1:0] BLACK = 3'b000;
    localparam logic [COLOUR_W-1:0] WHITE = 3'b111;

    typedef enum logic [1:0] {
        DRAIN_IDLE,
        DRAIN_READ,
        DRAIN_CHECK,
        DRAIN_WRITE
    } drain_state_e;

    // Linear address y*160 + x without a multiplier: 160 = 128 + 32.
    function automatic logic [FB_ADDR_W-1:0] pixel_addr(input logic [7:0] x, input logic [6:0] y);
        logic [FB_ADDR_W-1:0] yw;
        yw = {8'b0, y};
        return (yw << 7) + (yw << 5) + {7'b0, x};
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO holding {fb address, colour} plot entries.
// Head entry is visible on rdata_o while not empty (show-ahead).
module pixel_fifo
    import duck_hunt_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = FIFO_W
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is a power of two).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/pixel_write_sink.sv
// Receives the pixel-plot stream, drops off-screen plots, buffers the rest and
// drains them to the framebuffer write port under ready/valid backpressure.
// Optional FB_COLLIDE_EN: read-before-write to flag drawing over a lit pixel.
module pixel_write_sink #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned H_RES = duck_hunt_pkg::H_RES,
    parameter int unsigned V_RES = duck_hunt_pkg::V_RES
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        plot,
    input  logic [7:0]  x,
    input  logic [6:0]  y,
    input  logic [2:0]  colour,
    output logic        ready,
    output logic [14:0] fb_addr,
    output logic [2:0]  fb_wdata,
    output logic        fb_we,
    input  logic        fb_wready,
    output logic        fb_re,
    input  logic [2:0]  fb_rdata,
    output logic        collision,
    output logic [7:0]  drop_count,
    output logic        idle
);

    import duck_hunt_pkg::*;

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic                 in_range;
    logic                 push;
    logic                 pop;
    logic [FIFO_W-1:0]    fifo_wdata;
    logic [FIFO_W-1:0]    fifo_rdata;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CW-1:0]        fifo_count;
    logic [CW-1:0]        count_d;

    logic                 ready_q;
    logic [7:0]           drop_q;
    drain_state_e         state_q;
    logic [FB_ADDR_W-1:0] addr_q;
    logic [COLOUR_W-1:0]  wdata_q;
    logic                 we_q;

    assign in_range   = (32'(x) < H_RES) && (32'(y) < V_RES);
    assign push       = plot && ready_q && in_range;
    assign pop        = !fifo_empty && ((state_q == DRAIN_IDLE) ||
                                        ((state_q == DRAIN_WRITE) && fb_wready));
    assign fifo_wdata = {pixel_addr(x, y), colour};

    pixel_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk_i   (clock),
        .rst_ni  (resetn),
        .push_i  (push),
        .wdata_i (fifo_wdata),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Occupancy after this cycle's push/pop; ready is registered from it so a
    // pop from a full FIFO only re-opens ready on the following cycle.
    always_comb begin
        count_d = fifo_count;
        case ({push, pop})
            2'b10:   count_d = fifo_count + CW'(1);
            2'b01:   count_d = fifo_count - CW'(1);
            default: count_d = fifo_count;
        endcase
    end

    // Registered accept handshake; low for the first cycle out of reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) ready_q <= 1'b0;
        else         ready_q <= (count_d != CW'(DEPTH));
    end

    // Saturating count of off-screen plots, independent of ready.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)                                    drop_q <= '0;
        else if (plot && !in_range && drop_q != 8'hFF)  drop_q <= drop_q + 8'd1;
    end

`ifdef FB_COLLIDE_EN
    logic re_q;
    logic coll_q;

    // Drain FSM: read the target pixel, check for collision, then write.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= DRAIN_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            coll_q  <= 1'b0;
        end else begin
            coll_q <= 1'b0;
            case (state_q)
                DRAIN_IDLE: if (pop) begin
                    addr_q  <= fifo_rdata[FIFO_W-1:COLOUR_W];
                    wdata_q <= fifo_rdata[COLOUR_W-1:0];
                    re_q    <= 1'b1;
                    state_q <= DRAIN_READ;
                end
                DRAIN_READ: begin
                    re_q    <= 1'b0;
                    state_q <= DRAIN_CHECK;
                end
                DRAIN_CHECK: begin
                    coll_q  <= (fb_rdata != BLACK) && (wdata_q != BLACK);
                    we_q    <= 1'b1;
                    state_q <= DRAIN_WRITE;
                end
                DRAIN_WRITE: if (fb_wready) begin
                    we_q <= 1'b0;
                    if (pop) begin
                        addr_q  <= fifo_rdata[FIFO_W-1:COLOUR_W];
                        wdata_q <= fifo_rdata[COLOUR_W-1:0];
                        re_q    <= 1'b1;
                        state_q <= DRAIN_READ;
                    end else begin
                        state_q <= DRAIN_IDLE;
                    end
                end
                default: state_q <= DRAIN_IDLE;
            endcase
        end
    end

    assign fb_re     = re_q;
    assign collision = coll_q;
`else
    logic unused_rdata;
    assign unused_rdata = ^fb_rdata;

    // Drain FSM: pop into the output registers and stream one pixel per cycle.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= DRAIN_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            case (state_q)
                DRAIN_IDLE: if (pop) begin
                    addr_q  <= fifo_rdata[FIFO_W-1:COLOUR_W];
                    wdata_q <= fifo_rdata[COLOUR_W-1:0];
                    we_q    <= 1'b1;
                    state_q <= DRAIN_WRITE;
                end
                DRAIN_WRITE: if (fb_wready) begin
                    if (pop) begin
                        addr_q  <= fifo_rdata[FIFO_W-1:COLOUR_W];
                        wdata_q <= fifo_rdata[COLOUR_W-1:0];
                    end else begin
                        we_q    <= 1'b0;
                        state_q <= DRAIN_IDLE;
                    end
                end
                default: state_q <= DRAIN_IDLE;
            endcase
        end
    end

    assign fb_re     = 1'b0;
    assign collision = 1'b0;
`endif

    assign ready      = ready_q;
    assign fb_addr    = addr_q;
    assign fb_wdata   = wdata_q;
    assign fb_we      = we_q;
    assign drop_count = drop_q;
    assign idle       = fifo_empty && (state_q == DRAIN_IDLE);

endmodule

// File: tb/tb_pixel_write_sink.sv
// Self-checking bench for pixel_write_sink (default build; FB_COLLIDE_EN adds a collision test).
module tb_pixel_write_sink;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        plot = 1'b0;
    logic [7:0]  x = 8'hFF;
    logic [6:0]  y = '0;
    logic [2:0]  colour = '0;
    logic        fb_wready = 1'b0;
    logic [2:0]  fb_rdata = '0;
    logic        ready;
    logic [14:0] fb_addr;
    logic [2:0]  fb_wdata;
    logic        fb_we;
    logic        fb_re;
    logic        collision;
    logic [7:0]  drop_count;
    logic        idle;

    always #5 clock = ~clock;

    pixel_write_sink #(.DEPTH(16), .H_RES(160), .V_RES(120)) dut (
        .clock(clock), .resetn(resetn), .plot(plot), .x(x), .y(y), .colour(colour),
        .ready(ready), .fb_addr(fb_addr), .fb_wdata(fb_wdata), .fb_we(fb_we),
        .fb_wready(fb_wready), .fb_re(fb_re), .fb_rdata(fb_rdata),
        .collision(collision), .drop_count(drop_count), .idle(idle)
    );

    typedef struct packed { logic [14:0] addr; logic [2:0] col; } wr_t;

    int  errors = 0;
    int  checks = 0;
    wr_t exp_q[$];
    wr_t obs_q[$];
    int  exp_drop = 0;
    int  coll_cycles = 0;
    int  re_cycles = 0;
    int  cur_run = 0;
    int  max_run = 0;

`ifdef FB_COLLIDE_EN
    localparam int LAT = 4;
    localparam int B2B_RUN = 1;
`else
    localparam int LAT = 2;
    localparam int B2B_RUN = 13;
`endif

    // Reference model and write monitor, sampled mid-cycle.
    always @(negedge clock) begin
        if (resetn) begin
            if (fb_we && fb_wready) obs_q.push_back({fb_addr, fb_wdata});
            if (plot) begin
                if (x >= 160 || y >= 120) begin
                    if (exp_drop < 255) exp_drop++;
                end else if (ready) begin
                    exp_q.push_back({15'(32'(y) * 160 + 32'(x)), colour});
                end
            end
            if (collision) coll_cycles++;
            if (fb_re) re_cycles++;
            if (fb_we) cur_run++; else cur_run = 0;
            if (cur_run > max_run) max_run = cur_run;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic p, input logic [7:0] xx, input logic [6:0] yy, input logic [2:0] c);
        plot = p; x = xx; y = yy; colour = c;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (idle && !plot) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", fb_we); end
        checks++; if (fb_re !== 1'b0) begin errors++; $display("FAIL rst_re: got %b want 0", fb_re); end
        checks++; if (collision !== 1'b0) begin errors++; $display("FAIL rst_coll: got %b want 0", collision); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL rst_drop: got %0d want 0", drop_count); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rst_idle: got %b want 1", idle); end
        checks++; if (fb_addr !== 15'd0 || fb_wdata !== 3'd0) begin
            errors++; $display("FAIL rst_out: got addr=%0d data=%0d want 0/0", fb_addr, fb_wdata); end
        resetn = 1'b1;
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_ready_first: got %b want 0", ready); end
        @(negedge clock);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %b want 1", ready); end
    endtask

    task automatic test_single();
        int k;
        bit seen;
        fb_wready = 1'b1;
        exp_q.delete(); obs_q.delete();
        tick();
        drive(1'b1, 8'd5, 7'd3, 3'd7);
        tick();
        drive(1'b0, 8'hFF, 7'd0, 3'd0);
        k = 1; seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (fb_we) begin seen = 1'b1; break; end
            k++;
        end
        checks++; if (!seen || k != LAT) begin errors++; $display("FAIL single_latency: got %0d (seen=%b) want %0d", k, seen, LAT); end
        checks++; if (fb_addr !== 15'd485) begin errors++; $display("FAIL single_addr: got %0d want 485", fb_addr); end
        checks++; if (fb_wdata !== 3'd7) begin errors++; $display("FAIL single_data: got %0d want 7", fb_wdata); end
        @(negedge clock);
        checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL single_one_beat: got we=%b want 0", fb_we); end
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL single_count: got %0d writes want 1", obs_q.size()); end
    endtask

    task automatic test_bounds();
        bit ok;
        fb_wready = 1'b1;
        exp_q.delete(); obs_q.delete();
        tick(); drive(1'b1, 8'd255, 7'd0, 3'd7);
        tick(); drive(1'b1, 8'd10, 7'd120, 3'd7);
        tick(); drive(1'b1, 8'd159, 7'd119, 3'd5);
        tick(); drive(1'b1, 8'd20, 7'd30, 3'd0);
        tick(); drive(1'b1, 8'd20, 7'd30, 3'd7);
        tick(); drive(1'b0, 8'hFF, 7'd0, 3'd0);
        wait_idle(50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bounds_idle: got timeout want idle"); end
        checks++; if (drop_count !== 8'd2) begin errors++; $display("FAIL bounds_drop: got %0d want 2", drop_count); end
        checks++; if (obs_q.size() < 1 || obs_q[0].addr !== 15'd19199) begin
            errors++; $display("FAIL bounds_corner: got %0d writes first addr=%0d want 19199",
                               obs_q.size(), obs_q.size() > 0 ? obs_q[0].addr : 15'd0); end
        checks++; if (obs_q.size() != exp_q.size() || exp_q.size() != 3) begin
            errors++; $display("FAIL bounds_count: got %0d writes want %0d (model) / 3", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL bounds_order[%0d]: got addr=%0d col=%0d want addr=%0d col=%0d",
                                   i, obs_q[i].addr, obs_q[i].col, exp_q[i].addr, exp_q[i].col); end
        end
    endtask

    task automatic test_backpressure();
        int accepted;
        bit ok;
        fb_wready = 1'b0;
        exp_q.delete(); obs_q.delete();
        accepted = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            drive(1'b1, 8'($urandom_range(0, 159)), 7'($urandom_range(0, 119)), 3'($urandom));
            @(negedge clock);
            if (ready) accepted++;
        end
        tick();
        drive(1'b0, 8'hFF, 7'd0, 3'd0);
        @(negedge clock);
        checks++; if (accepted != 17) begin errors++; $display("FAIL bp_accepted: got %0d want 17", accepted); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b want 0", ready); end
        checks++; if (fb_we !== 1'b1 || obs_q.size() != 0) begin
            errors++; $display("FAIL bp_held: got we=%b writes=%0d want 1/0", fb_we, obs_q.size()); end
        fb_wready = 1'b1;
        wait_idle(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_idle: got timeout want idle"); end
        checks++; if (obs_q.size() != 17 || exp_q.size() != 17) begin
            errors++; $display("FAIL bp_count: got %0d writes want 17 (model %0d)", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL bp_order[%0d]: got addr=%0d col=%0d want addr=%0d col=%0d",
                                   i, obs_q[i].addr, obs_q[i].col, exp_q[i].addr, exp_q[i].col); end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        fb_wready = 1'b1;
        exp_q.delete(); obs_q.delete();
        tick();
        max_run = 0;
        for (int i = 0; i < 13; i++) begin
            drive(1'b1, 8'($urandom_range(0, 159)), 7'($urandom_range(0, 119)), 3'($urandom));
            tick();
        end
        drive(1'b0, 8'hFF, 7'd0, 3'd0);
        wait_idle(100, ok);
        checks++; if (!ok || idle !== 1'b1) begin errors++; $display("FAIL b2b_idle: got idle=%b want 1", idle); end
        checks++; if (max_run != B2B_RUN) begin errors++; $display("FAIL b2b_run: got %0d want %0d", max_run, B2B_RUN); end
        checks++; if (obs_q.size() != 13 || exp_q.size() != 13) begin
            errors++; $display("FAIL b2b_count: got %0d writes want 13 (model %0d)", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL b2b_order[%0d]: got addr=%0d col=%0d want addr=%0d col=%0d",
                                   i, obs_q[i].addr, obs_q[i].col, exp_q[i].addr, exp_q[i].col); end
        end
    endtask

    task automatic test_reset_mid();
        fb_wready = 1'b0;
        exp_q.delete(); obs_q.delete();
        for (int i = 0; i < 6; i++) begin
            tick();
            drive(1'b1, 8'($urandom_range(0, 159)), 7'($urandom_range(0, 119)), 3'd6);
        end
        tick();
        drive(1'b0, 8'hFF, 7'd0, 3'd0);
        repeat (2) @(negedge clock);
        checks++; if (fb_we !== 1'b1) begin errors++; $display("FAIL rmid_pre_we: got %b want 1", fb_we); end
        #2;
        resetn = 1'b0;
        exp_drop = 0;
        #1;
        checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL rmid_we_drop: got %b want 0", fb_we); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rmid_idle: got %b want 1", idle); end
        exp_q.delete(); obs_q.delete();
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        fb_wready = 1'b1;
        repeat (30) @(negedge clock);
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL rmid_stale: got %0d writes want 0", obs_q.size()); end
        checks++; if (idle !== 1'b1 || drop_count !== 8'd0) begin
            errors++; $display("FAIL rmid_after: got idle=%b drop=%0d want 1/0", idle, drop_count); end
    endtask

    task automatic test_random();
        bit ok;
        exp_q.delete(); obs_q.delete();
        for (int i = 0; i < 400; i++) begin
            tick();
            fb_wready = ($urandom % 3) != 0;
            drive(($urandom % 4) != 0,
                  (($urandom % 8) == 0) ? 8'hFF : 8'($urandom_range(0, 175)),
                  7'($urandom_range(0, 127)), 3'($urandom));
        end
        tick();
        drive(1'b0, 8'hFF, 7'd0, 3'd0);
        fb_wready = 1'b1;
        wait_idle(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rand_idle: got timeout want idle"); end
        checks++; if (drop_count !== 8'(exp_drop)) begin errors++; $display("FAIL rand_drop: got %0d want %0d", drop_count, exp_drop); end
        checks++; if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL rand_count: got %0d writes want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL rand_order[%0d]: got addr=%0d col=%0d want addr=%0d col=%0d",
                                   i, obs_q[i].addr, obs_q[i].col, exp_q[i].addr, exp_q[i].col); end
        end
    endtask

    task automatic test_drop_saturate();
        fb_wready = 1'b0;
        for (int i = 0; i < 270; i++) begin
            tick();
            drive(1'b1, 8'd200, 7'($urandom_range(0, 127)), 3'd1);
        end
        tick();
        drive(1'b0, 8'hFF, 7'd0, 3'd0);
        @(negedge clock);
        checks++; if (drop_count !== 8'd255) begin errors++; $display("FAIL drop_sat: got %0d want 255", drop_count); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL drop_sat_idle: got %b want 1", idle); end
    endtask

`ifdef FB_COLLIDE_EN
    task automatic test_collide();
        bit ok;
        fb_wready = 1'b1;
        fb_rdata = 3'd7;
        coll_cycles = 0;
        tick(); drive(1'b1, 8'd40, 7'd40, 3'd7);
        tick(); drive(1'b0, 8'hFF, 7'd0, 3'd0);
        wait_idle(50, ok);
        @(negedge clock);
        checks++; if (!ok || coll_cycles != 1) begin errors++; $display("FAIL coll_hit: got %0d pulse cycles want 1", coll_cycles); end
        coll_cycles = 0;
        tick(); drive(1'b1, 8'd40, 7'd40, 3'd0);
        tick(); drive(1'b0, 8'hFF, 7'd0, 3'd0);
        wait_idle(50, ok);
        @(negedge clock);
        checks++; if (!ok || coll_cycles != 0) begin errors++; $display("FAIL coll_erase: got %0d pulse cycles want 0", coll_cycles); end
        fb_rdata = 3'd0;
    endtask
`else
    task automatic test_no_collide();
        checks++; if (re_cycles != 0 || coll_cycles != 0) begin
            errors++; $display("FAIL no_collide: got re=%0d coll=%0d cycles want 0/0", re_cycles, coll_cycles); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_bounds();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef FB_COLLIDE_EN
        test_collide();
`else
        test_no_collide();
`endif
        test_drop_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
